mod_counter: RTL and testbench

- Parametrised successor to the library `counter`: a WIDTH-bit up/down counter with a runtime modulus (`max`) and a programmable `step`.
- Supports parallel load, and selects wrap or saturate on overflow/underflow.
- Provides a cascade terminal-count output, zero/max flags and a registered wrap pulse.
- Used as a general datapath/timing counter in the FSM-D library, alongside Register and shift_register.

---
 rtl/mod_counter_if.sv | 30 +++
 rtl/mod_counter.sv | 96 +++++++++
 tb/tb_mod_counter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mod_counter_if.sv
// Bus bundle for mod_counter: control/config inputs and count/flag outputs.
// The master modport drives the controls; the slave modport is the counter.
interface mod_counter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] max;
  logic [WIDTH-1:0] step;
  logic             en;
  logic             up;
  logic             load;
  logic             sat;
  logic             ovf_clr;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             is_zero;
  logic             is_max;
  logic             wrapped;
  logic             ovf;

  modport master (
    output D, max, step, en, up, load, sat, ovf_clr,
    input  Q, tc, is_zero, is_max, wrapped, ovf
  );

  modport slave (
    input  D, max, step, en, up, load, sat, ovf_clr,
    output Q, tc, is_zero, is_max, wrapped, ovf
  );
endinterface

// File: rtl/mod_counter.sv
// WIDTH-bit up/down modulus counter with programmable step, load, wrap/saturate.
// Define MOD_COUNTER_STICKY_EN to enable the sticky overflow flag (ovf/ovf_clr).
module mod_counter #(
  parameter int WIDTH = 8
) (
  input  logic         clock,
  input  logic         clr,
  mod_counter_if.slave bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrapped_q, wrapped_d;

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   max_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             up_event;
  logic             down_event;
  logic             event_cond;
  logic             count_event;

  // One extra bit of headroom so Q + step can never silently wrap.
  always_comb begin
    q_ext    = {1'b0, q_q};
    max_ext  = {1'b0, bus.max};
    step_ext = (bus.step == '0) ? {{WIDTH{1'b0}}, 1'b1} : {1'b0, bus.step};
    sum_ext  = q_ext + step_ext;
    diff_ext = q_ext - step_ext;
  end

  always_comb begin
    up_event    = (sum_ext > max_ext) || (q_ext > max_ext);
    down_event  = (q_ext < step_ext);
    event_cond  = bus.up ? up_event : down_event;
    count_event = bus.en && !bus.load && event_cond;
  end

  always_comb begin
    q_d       = q_q;
    wrapped_d = 1'b0;
    if (bus.load) begin
      q_d = (bus.D > bus.max) ? bus.max : bus.D;
    end else if (bus.en) begin
      wrapped_d = event_cond;
      if (bus.up) begin
        if (up_event) q_d = bus.sat ? bus.max : '0;
        else          q_d = sum_ext[WIDTH-1:0];
      end else begin
        if (down_event)            q_d = bus.sat ? '0 : bus.max;
        else if (q_ext > max_ext)  q_d = bus.max;
        else                       q_d = diff_ext[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      q_q       <= '0;
      wrapped_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      wrapped_q <= wrapped_d;
    end
  end

`ifdef MOD_COUNTER_STICKY_EN
  logic ovf_q, ovf_d;

  // A new event wins over a simultaneous clear request.
  always_comb begin
    ovf_d = ovf_q;
    if (count_event)      ovf_d = 1'b1;
    else if (bus.ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (clr) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = bus.ovf_clr;
  assign bus.ovf        = 1'b0;
`endif

  assign bus.Q       = q_q;
  assign bus.wrapped = wrapped_q;
  assign bus.tc      = count_event && !clr;
  assign bus.is_zero = (q_q == '0);
  assign bus.is_max  = (q_q == bus.max);

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: directed scenarios plus randomized traffic,
// expectations from an integer-arithmetic model; ovf expectation follows MOD_COUNTER_STICKY_EN.
module tb_mod_counter;

  logic clock;
  logic clr;

  mod_counter_if #(.WIDTH(8)) bus ();

  mod_counter #(.WIDTH(8)) dut (
    .clock (clock),
    .clr   (clr),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] q;
    logic       tc;
    logic       zero;
    logic       at_max;
    logic       wr;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  int m_q   = 0;
  bit m_wr  = 0;
  bit m_ovf = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every cycle with a pending expectation, compare the visible outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("Q",       {24'd0, bus.Q},      {24'd0, e.q});
        chk("tc",      {31'd0, bus.tc},     {31'd0, e.tc});
        chk("is_zero", {31'd0, bus.is_zero},{31'd0, e.zero});
        chk("is_max",  {31'd0, bus.is_max}, {31'd0, e.at_max});
        chk("wrapped", {31'd0, bus.wrapped},{31'd0, e.wr});
        chk("ovf",     {31'd0, bus.ovf},    {31'd0, e.ovf});
      end
    end
  end

  task automatic cyc(input bit c, input bit ld, input bit e, input bit u, input bit st,
                     input bit oc, input int d, input int mx, input int sp);
    exp_t x;
    int   s;
    bit   ev_cond;
    bit   ev;
    @(posedge clock);
    #1;
    clr         = c;
    bus.load    = ld;
    bus.en      = e;
    bus.up      = u;
    bus.sat     = st;
    bus.ovf_clr = oc;
    bus.D       = d[7:0];
    bus.max     = mx[7:0];
    bus.step    = sp[7:0];

    s       = (sp == 0) ? 1 : sp;
    ev_cond = u ? ((m_q + s > mx) || (m_q > mx)) : (m_q < s);
    ev      = !c && !ld && e && ev_cond;

    x.q      = m_q[7:0];
    x.tc     = ev;
    x.zero   = (m_q == 0);
    x.at_max = (m_q == mx);
    x.wr     = m_wr;
    x.ovf    = m_ovf;
    exp_q.push_back(x);

    if (c) begin
      m_q  = 0;
      m_wr = 0;
    end else if (ld) begin
      m_q  = (d > mx) ? mx : d;
      m_wr = 0;
    end else if (e) begin
      m_wr = ev;
      if (u) m_q = ev ? (st ? mx : 0) : m_q + s;
      else   m_q = ev ? (st ? 0 : mx) : ((m_q > mx) ? mx : m_q - s);
    end else begin
      m_wr = 0;
    end
`ifdef MOD_COUNTER_STICKY_EN
    if (c)       m_ovf = 0;
    else if (ev) m_ovf = 1;
    else if (oc) m_ovf = 0;
`else
    m_ovf = 0;
`endif
  endtask

  initial begin
    int guard;
    clr = 1'b1;
    bus.D = '0; bus.max = 8'hFF; bus.step = 8'd1;
    bus.en = 0; bus.up = 1; bus.load = 0; bus.sat = 0; bus.ovf_clr = 0;
    repeat (2) @(posedge clock);

    // clr overrides load and en mid-count
    cyc(0, 1, 0, 1, 0, 0, 8'h37, 255, 1);
    cyc(1, 1, 1, 1, 0, 0, 8'h10, 255, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 255, 1);

    // wrap-mode mod-10 count
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 1, 0, 0, 0, 9, 1);

    // saturating down count by 4
    cyc(0, 1, 0, 0, 1, 0, 6, 9, 4);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1, 0, 0, 9, 4);
    cyc(0, 0, 0, 0, 1, 0, 0, 9, 4);

    // load clamp, then lowering max while counting down
    cyc(0, 1, 0, 0, 0, 0, 50, 20, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 20, 1);
    cyc(0, 0, 1, 0, 0, 0, 0, 10, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 10, 1);
    // max lowered below Q while counting up is an event
    cyc(0, 1, 0, 1, 0, 0, 30, 40, 1);
    cyc(0, 0, 1, 1, 1, 0, 0, 12, 1);
    cyc(0, 0, 0, 1, 1, 0, 0, 12, 1);

    // step 0 acts as 1, full-range wrap without truncation
    cyc(0, 1, 0, 1, 0, 0, 8'hFE, 255, 0);
    cyc(0, 0, 1, 1, 0, 0, 0, 255, 0);
    cyc(0, 0, 1, 1, 0, 0, 0, 255, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 255, 0);
    // large step near the top
    cyc(0, 1, 0, 1, 0, 0, 8'hF0, 255, 8'h20);
    cyc(0, 0, 1, 1, 1, 0, 0, 255, 8'h20);
    cyc(0, 0, 0, 1, 1, 0, 0, 255, 8'h20);

    // max = 0 in every mode
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, i[0], i[1], 0, 0, 0, 3);

    // sticky overflow: set, hold, clear, clear-vs-event
    cyc(0, 1, 0, 1, 0, 0, 9, 9, 1);
    cyc(0, 0, 1, 1, 0, 0, 0, 9, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0, 0, 9, 1);
    cyc(0, 0, 0, 1, 0, 1, 0, 9, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 9, 1);
    cyc(0, 1, 0, 1, 0, 0, 9, 9, 1);
    cyc(0, 0, 1, 1, 0, 1, 0, 9, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 9, 1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int mx;
      mx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
      cyc($urandom_range(0, 63) == 0,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 255),
          mx,
          ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 20));
    end
    cyc(0, 0, 0, 1, 0, 0, 0, 255, 1);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clock);
      guard++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
